// File: rtl/dip_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//
// Debounces one already-synchronised switch bit against a shared sample tick.
// A new level is accepted only after it has been seen on STABLE_CNT
// consecutive ticks; a single tick showing the old level throws away the
// progress made so far.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   tick   in   one-cycle sample strobe from the timebase tap edge detector
//   s2     in   synchronised switch level
//   val    out  debounced switch level
//   accept out  combinational pulse, high in the cycle whose clock edge
//               loads a new level into val
// ---------------------------------------------------------------------------
module debounce_bit #(
   parameter int STABLE_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic s2,
   output logic val,
   output logic accept
);

   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PENDING = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             val_q, val_d;

   // Next-state logic. Nothing moves between ticks. In IDLE the first
   // differing sample counts as sample one; in PENDING a matching sample is
   // treated as a bounce and everything returns to IDLE. Acceptance always
   // leaves the bit idle with a cleared counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      accept  = 1'b0;
      if (tick) begin
         if (s2 != val_q) begin
            if (state_q == ST_IDLE) begin
               if (STABLE_CNT == 1) begin
                  accept = 1'b1;
               end else begin
                  state_d = ST_PENDING;
                  cnt_d   = CNT_ONE;
               end
            end else if (cnt_q == CNT_LAST) begin
               accept = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end
      if (accept) begin
         val_d   = s2;
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   // State, counter and debounced level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
      end
   end

   assign val = val_q;

endmodule

// File: rtl/dip_debounce.sv
// ---------------------------------------------------------------------------
// dip_debounce
//
// Conditions raw DIP-switch pins for use inside the clk domain. Each pin is
// passed through a two-flop synchroniser, then debounced by its own
// debounce_bit instance that samples only on rising edges of one selected
// timebase tap. Produces a stable value, a one-cycle change strobe and a mask
// of the bits that changed.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   taps     in   [NTAPS-1:0] free-running timebase tap bits
//   raw      in   [WIDTH-1:0] asynchronous switch levels, 1 = on
//   val      out  [WIDTH-1:0] debounced switch value
//   changed  out  one-cycle pulse in the cycle val takes a new value
//   chg_mask out  [WIDTH-1:0] bits of val that changed; zero when changed=0
// ---------------------------------------------------------------------------
module dip_debounce #(
   parameter int WIDTH      = 4,
   parameter int NTAPS      = 6,
   parameter int TAP_SEL    = 3,
   parameter int STABLE_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NTAPS-1:0] taps,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] val,
   output logic             changed,
   output logic [WIDTH-1:0] chg_mask
);

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic             tap_q, tap_d;
   logic             changed_q, changed_d;
   logic [WIDTH-1:0] chg_mask_q, chg_mask_d;
   logic             tick;
   logic [WIDTH-1:0] accept;
   logic             unused_taps;

   // Only one tap drives the tick; the rest of the bus is intentionally ignored.
   assign unused_taps = ^taps;

   // A tick is the first cycle the selected tap is seen high. tap_q resets
   // low, so a tap already high when reset releases ticks immediately.
   assign tick = taps[TAP_SEL] & ~tap_q;

   // Next values for the synchroniser, edge detector and change reporting.
   // changed/chg_mask are loaded from this cycle's accepts so they line up
   // with the edge on which the debounced bits update.
   always_comb begin
      s1_d       = raw;
      s2_d       = s1_q;
      tap_d      = taps[TAP_SEL];
      changed_d  = |accept;
      chg_mask_d = accept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         tap_q      <= 1'b0;
         changed_q  <= 1'b0;
         chg_mask_q <= '0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         tap_q      <= tap_d;
         changed_q  <= changed_d;
         chg_mask_q <= chg_mask_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_CNT(STABLE_CNT)
      ) u_bit (
         .clk   (clk),
         .rst   (rst),
         .tick  (tick),
         .s2    (s2_q[i]),
         .val   (val[i]),
         .accept(accept[i])
      );
   end

   assign changed  = changed_q;
   assign chg_mask = chg_mask_q;

endmodule

// File: tb/tb_dip_debounce.sv
// ---------------------------------------------------------------------------
// tb_dip_debounce
//
// Directed bench for dip_debounce with WIDTH=4, TAP_SEL=0, STABLE_CNT=4.
// taps[0] is high for one clk in every eight. Each expected change pulse
// (value, mask and the tick number it must appear on) is queued when the
// stimulus is applied; a monitor captures every real pulse and the two
// queues are drained against each other after each scenario.
// ---------------------------------------------------------------------------
module tb_dip_debounce;

   typedef struct packed {
      logic [3:0]  v;
      logic [3:0]  m;
      logic [31:0] t;
   } event_t;

   logic       clk;
   logic       rst;
   logic [5:0] taps;
   logic [3:0] raw;
   logic [3:0] val;
   logic       changed;
   logic [3:0] chg_mask;

   int         errors;
   int         checks;
   int         phase;
   int         tick_no;
   logic [3:0] prev_val;
   event_t     exp_q[$];
   event_t     obs_q[$];

   dip_debounce #(
      .WIDTH     (4),
      .NTAPS     (6),
      .TAP_SEL   (0),
      .STABLE_CNT(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .taps    (taps),
      .raw     (raw),
      .val     (val),
      .changed (changed),
      .chg_mask(chg_mask)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Timebase: taps[0] high for one clk in every eight, numbered by tick_no.
   initial begin
      taps    = '0;
      phase   = 1;
      tick_no = 0;
      forever begin
         @(negedge clk);
         phase = (phase == 7) ? 0 : phase + 1;
         taps[0] = (phase == 0);
         if (phase == 0) tick_no++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r);
      raw = r;
   endtask

   task automatic expectPulse(input logic [3:0] v, input logic [3:0] m, input int t);
      event_t e;
      e.v = v;
      e.m = m;
      e.t = 32'(t);
      exp_q.push_back(e);
   endtask

   // Returns one ns after the negedge that follows a tick's sampling edge.
   task automatic waitTicks(input int n);
      repeat (n) begin
         do @(posedge clk); while (taps[0] !== 1'b1);
         @(negedge clk);
         #1;
      end
   endtask

   // Drain the scoreboard: every expected pulse must have been seen in
   // order, on the right tick, and nothing extra may be left over.
   task automatic checkScoreboard(input string tag);
      event_t e;
      event_t o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput({tag, "_pulse_seen"}, 32'(obs_q.size() > 0), 32'd1);
         if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checkOutput({tag, "_val"},  32'(o.v), 32'(e.v));
            checkOutput({tag, "_mask"}, 32'(o.m), 32'(e.m));
            checkOutput({tag, "_tick"}, o.t, e.t);
         end
      end
      checkOutput({tag, "_extra_pulses"}, 32'(obs_q.size()), 32'd0);
      obs_q.delete();
   endtask

   // Monitor: records each change pulse, and checks that the mask is quiet
   // and val holds steady on every cycle without a pulse.
   initial begin
      event_t o;
      prev_val = '0;
      forever begin
         @(negedge clk);
         if (changed === 1'b1) begin
            o.v = val;
            o.m = chg_mask;
            o.t = 32'(tick_no);
            obs_q.push_back(o);
         end else if (rst === 1'b0) begin
            checkOutput("mask_idle", 32'(chg_mask), 32'd0);
            checkOutput("val_hold", 32'(val), 32'(prev_val));
         end
         prev_val = val;
      end
   end

   initial begin
      int k;
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      applyStimulus(4'hF);

      // Reset with all switches on: outputs stay clear throughout.
      repeat (20) begin
         @(negedge clk);
         #1;
         checkOutput("rst_val", 32'(val), 32'd0);
         checkOutput("rst_changed", 32'(changed), 32'd0);
         checkOutput("rst_mask", 32'(chg_mask), 32'd0);
      end
      waitTicks(1);
      rst = 1'b0;
      k = tick_no;
      expectPulse(4'hF, 4'hF, k + 4);
      waitTicks(3);
      checkOutput("rst_release_early", 32'(val), 32'd0);
      waitTicks(3);
      checkOutput("rst_release_val", 32'(val), 32'hF);
      checkScoreboard("reset");

      // Clean change: back to 0, then 4'h5.
      applyStimulus(4'h0);
      expectPulse(4'h0, 4'hF, tick_no + 4);
      waitTicks(6);
      applyStimulus(4'h5);
      expectPulse(4'h5, 4'h5, tick_no + 4);
      waitTicks(6);
      checkOutput("clean_val", 32'(val), 32'h5);
      checkScoreboard("clean");

      // Bounce on bit 0: clear it, then 3 ticks high, 1 tick low, high held.
      applyStimulus(4'h4);
      expectPulse(4'h4, 4'h1, tick_no + 4);
      waitTicks(6);
      applyStimulus(4'h5);
      waitTicks(3);
      applyStimulus(4'h4);
      waitTicks(1);
      applyStimulus(4'h5);
      expectPulse(4'h5, 4'h1, tick_no + 4);
      waitTicks(3);
      checkOutput("bounce_early", 32'(val), 32'h4);
      waitTicks(3);
      checkOutput("bounce_val", 32'(val), 32'h5);
      checkScoreboard("bounce");

      // Inter-tick glitch on bit 2 (cleared first).
      applyStimulus(4'h1);
      expectPulse(4'h1, 4'h4, tick_no + 4);
      waitTicks(6);
      checkScoreboard("glitch_setup");
      waitTicks(1);
      @(negedge clk);
      #1;
      applyStimulus(4'h5);
      repeat (3) @(negedge clk);
      #1;
      applyStimulus(4'h1);
      waitTicks(6);
      checkOutput("glitch_val", 32'(val), 32'h1);
      checkScoreboard("glitch");

      // Reset mid-pending: bit 1 rises, reset after its second tick.
      applyStimulus(4'h3);
      waitTicks(2);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("midrst_val", 32'(val), 32'd0);
      rst = 1'b0;
      k = tick_no;
      obs_q.delete();
      expectPulse(4'h3, 4'h3, k + 4);
      waitTicks(3);
      checkOutput("midrst_early", 32'(val), 32'd0);
      waitTicks(3);
      checkOutput("midrst_val_final", 32'(val), 32'h3);
      checkScoreboard("midrst");

      // Independent bits: bit 0 rises, bit 3 two ticks later.
      applyStimulus(4'h0);
      expectPulse(4'h0, 4'h3, tick_no + 4);
      waitTicks(6);
      applyStimulus(4'h1);
      k = tick_no;
      expectPulse(4'h1, 4'h1, k + 4);
      waitTicks(2);
      applyStimulus(4'h9);
      expectPulse(4'h9, 4'h8, k + 6);
      waitTicks(8);
      checkOutput("indep_val", 32'(val), 32'h9);
      checkScoreboard("indep");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
